// File: rtl/uart_auto_baud_det.sv
// Auto-baud detector: times the alternating pulses of an incoming 0x55 character,
// checks their spread and derives the oversample divider for clk_ctl.
module uart_auto_baud_det #(
  parameter int CNT_W     = 20,
  parameter int BAUD_W    = 12,
  parameter int NUM_PULSE = 8,
  parameter int TOL       = 16,
  parameter int OVS_LOG2  = 4,
  parameter int SYNC_STG  = 2
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              cfg_auto_det,
  input  logic              rxd,
  output logic [BAUD_W-1:0] auto_baud_16x,
  output logic              auto_tx_enb,
  output logic              auto_rx_enb,
  output logic              auto_det_done,
  output logic              auto_det_err,
  output logic              auto_det_busy
);

  localparam int PL2   = $clog2(NUM_PULSE);
  localparam int LEN_W = CNT_W + 1;
  localparam int SUM_W = CNT_W + PL2 + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEAS,
    S_CHECK,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STG-1:0] sync_q;
  logic                rxd_d;
  logic                rxd_s, pedge, nedge;
  logic [CNT_W-1:0]    cnt;
  logic                timeout;
  logic [LEN_W-1:0]    len;
  logic [SUM_W-1:0]    sum, sum_nx;
  logic [LEN_W-1:0]    min_q, max_q, spread;
  logic [LEN_W-1:0]    bit_q, bit_c, b_c, bm1;
  logic [BAUD_W-1:0]   baud_c;
  logic [PL2-1:0]      idx;
  logic                exp_edge, bad_edge, last_pulse, spread_bad, drain_ok;

  assign rxd_s   = sync_q[SYNC_STG-1];
  assign pedge   = rxd_s & ~rxd_d;
  assign nedge   = ~rxd_s & rxd_d;
  assign timeout = &cnt;

  // The edge cycle itself belongs to the pulse it ends, so the length is cnt+1.
  assign len    = {1'b0, cnt} + LEN_W'(1);
  assign sum_nx = sum + SUM_W'(len);

  // Even pulses are low (ended by a rising edge), odd pulses are high.
  assign exp_edge   = idx[0] ? nedge : pedge;
  assign bad_edge   = idx[0] ? pedge : nedge;
  assign last_pulse = (idx == PL2'(NUM_PULSE - 1));

  assign spread     = max_q - min_q;
  assign spread_bad = (spread > LEN_W'(TOL));
  assign bit_c      = LEN_W'(sum >> PL2);
  assign b_c        = bit_c >> OVS_LOG2;
  assign bm1        = b_c - LEN_W'(1);

  always_comb begin
    baud_c = '0;
    if (b_c > LEN_W'(1)) begin
      if (|bm1[LEN_W-1:BAUD_W]) baud_c = '1;
      else                      baud_c = bm1[BAUD_W-1:0];
    end
  end

  assign drain_ok = rxd_s && ({2'b00, cnt} >= {1'b0, bit_q, 1'b0});

  always_ff @(posedge mclk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cfg_auto_det && nedge) state_nx = S_MEAS;
      S_MEAS: begin
        if (!cfg_auto_det)           state_nx = S_IDLE;
        else if (exp_edge)           state_nx = last_pulse ? S_CHECK : S_MEAS;
        else if (bad_edge || timeout) state_nx = S_ERR;
      end
      S_CHECK: begin
        if (!cfg_auto_det)   state_nx = S_IDLE;
        else if (spread_bad) state_nx = S_ERR;
        else                 state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (!cfg_auto_det)          state_nx = S_IDLE;
        else if (drain_ok)          state_nx = S_DONE;
        else if (!rxd_s && timeout) state_nx = S_ERR;
      end
      S_DONE:  if (!cfg_auto_det) state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      sync_q        <= '1;
      rxd_d         <= 1'b1;
      cnt           <= '0;
      idx           <= '0;
      sum           <= '0;
      min_q         <= '1;
      max_q         <= '0;
      bit_q         <= '0;
      auto_baud_16x <= '0;
      auto_tx_enb   <= 1'b0;
      auto_rx_enb   <= 1'b0;
      auto_det_done <= 1'b0;
      auto_det_err  <= 1'b0;
      auto_det_busy <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], rxd};
      rxd_d  <= rxd_s;

      if (pedge || nedge) cnt <= '0;
      else if (!timeout)  cnt <= cnt + CNT_W'(1);

      if (state == S_IDLE && cfg_auto_det && nedge) begin
        idx   <= '0;
        sum   <= '0;
        min_q <= '1;
        max_q <= '0;
      end

      if (state == S_MEAS && cfg_auto_det && exp_edge) begin
        sum <= sum_nx;
        idx <= idx + PL2'(1);
        if (len < min_q) min_q <= len;
        if (len > max_q) max_q <= len;
      end

      if (state == S_CHECK && cfg_auto_det) begin
        bit_q <= bit_c;
        if (!spread_bad) auto_baud_16x <= baud_c;
      end

      auto_tx_enb   <= (state_nx == S_DONE);
      auto_rx_enb   <= (state_nx == S_DONE);
      auto_det_done <= (state_nx == S_DONE) && (state != S_DONE);
      auto_det_err  <= (state_nx == S_ERR) && (state != S_ERR);
      auto_det_busy <= (state_nx == S_MEAS) || (state_nx == S_CHECK) ||
                       (state_nx == S_DRAIN);
    end
  end

endmodule

// File: tb/tb_uart_auto_baud_det.sv
// Bench for uart_auto_baud_det: random 'U' frames against an arithmetic reference,
// with a queue-based scoreboard popped by per-instance monitors on done/err pulses.
module tb_uart_auto_baud_det;

  logic        mclk = 1'b0;
  logic        reset_n;
  logic        cfg1, rxd1, cfg2, rxd2;
  logic [11:0] baud1;
  logic [3:0]  baud2;
  logic        tx1, rx1, done1, err1, busy1;
  logic        tx2, rx2, done2, err2, busy2;

  always #10 mclk = ~mclk;

  uart_auto_baud_det u_dut1 (
    .mclk(mclk), .reset_n(reset_n), .cfg_auto_det(cfg1), .rxd(rxd1),
    .auto_baud_16x(baud1), .auto_tx_enb(tx1), .auto_rx_enb(rx1),
    .auto_det_done(done1), .auto_det_err(err1), .auto_det_busy(busy1)
  );

  // Small counter and divider widths keep timeout and saturation cases short.
  uart_auto_baud_det #(.CNT_W(12), .BAUD_W(4)) u_dut2 (
    .mclk(mclk), .reset_n(reset_n), .cfg_auto_det(cfg2), .rxd(rxd2),
    .auto_baud_16x(baud2), .auto_tx_enb(tx2), .auto_rx_enb(rx2),
    .auto_det_done(done2), .auto_det_err(err2), .auto_det_busy(busy2)
  );

  typedef struct {
    bit err;
    int baud;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   total = 0;
  int   bad   = 0;
  int   good1 = 0;
  int   good2 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge mclk) begin
    if (reset_n && (done1 || err1)) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected: got done=%0b err=%0b expected no event", done1, err1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_err_kind", int'(err1), int'(e.err));
        chk("dut1_baud", int'(baud1), e.baud);
        chk("dut1_enables", int'({tx1, rx1}), e.err ? 0 : 3);
      end
    end
  end

  always @(negedge mclk) begin
    if (reset_n && (done2 || err2)) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL dut2_unexpected: got done=%0b err=%0b expected no event", done2, err2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2_err_kind", int'(err2), int'(e.err));
        chk("dut2_baud", int'(baud2), e.baud);
        chk("dut2_enables", int'({tx2, rx2}), e.err ? 0 : 3);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic set_rxd(input int which, input logic v);
    if (which == 1) rxd1 = v; else rxd2 = v;
  endtask

  task automatic set_cfg(input int which, input logic v);
    if (which == 1) cfg1 = v; else cfg2 = v;
  endtask

  function automatic int busy_of(input int which);
    return (which == 1) ? int'(busy1) : int'(busy2);
  endfunction

  function automatic int enb_of(input int which);
    return (which == 1) ? int'({tx1, rx1}) : int'({tx2, rx2});
  endfunction

  function automatic int qsize(input int which);
    return (which == 1) ? q1.size() : q2.size();
  endfunction

  task automatic wait_q(input int which);
    for (int i = 0; i < 300 && qsize(which) != 0; i++) hold(1);
    if (qsize(which) != 0) begin
      total++; bad++;
      $display("FAIL dut%0d_no_event: got %0d outstanding expected 0", which, qsize(which));
      if (which == 1) q1.delete(); else q2.delete();
    end
  endtask

  // Reference: average pulse width, tolerance on the spread, then divide by 16.
  task automatic run_frame(input int which, input int w[8]);
    int   sum, mn, mx, bitw, b, baud, maxb;
    exp_t e;
    sum = 0; mn = w[0]; mx = w[0];
    foreach (w[i]) begin
      sum += w[i];
      if (w[i] < mn) mn = w[i];
      if (w[i] > mx) mx = w[i];
    end
    bitw = sum / 8;
    maxb = (which == 1) ? 4095 : 15;
    b    = bitw / 16;
    baud = (b > 1) ? b - 1 : 0;
    if (baud > maxb) baud = maxb;
    e.err = (mx - mn) > 16;
    if (e.err) e.baud = (which == 1) ? good1 : good2;
    else begin
      e.baud = baud;
      if (which == 1) good1 = baud; else good2 = baud;
    end
    if (which == 1) q1.push_back(e); else q2.push_back(e);

    for (int i = 0; i < 8; i++) begin
      set_rxd(which, (i % 2) == 1);
      if (i == 4) chk("busy_mid_frame", busy_of(which), 1);
      hold(w[i]);
    end
    set_rxd(which, 1'b0);
    hold(bitw);
    set_rxd(which, 1'b1);
    hold(2 * bitw + 40);
    wait_q(which);
    if (!e.err) chk("enables_held", enb_of(which), 3);
    set_cfg(which, 1'b0);
    hold(2);
    chk("enables_after_drop", enb_of(which), 0);
    chk("busy_after_drop", busy_of(which), 0);
    set_cfg(which, 1'b1);
    hold(2);
  endtask

  task automatic uniform(input int which, input int bitw, input int bump_idx, input int bump);
    int w[8];
    foreach (w[i]) w[i] = bitw + ((i == bump_idx) ? bump : 0);
    run_frame(which, w);
  endtask

  initial begin
    int w[8];
    reset_n = 1'b0;
    cfg1 = 1'b0; rxd1 = 1'b1;
    cfg2 = 1'b0; rxd2 = 1'b1;
    hold(5);
    chk("rst_baud1", int'(baud1), 0);
    chk("rst_enb1", enb_of(1), 0);
    chk("rst_pulses1", int'({done1, err1, busy1}), 0);
    chk("rst_baud2", int'(baud2), 0);
    reset_n = 1'b1;
    cfg1 = 1'b1; cfg2 = 1'b1;
    hold(5);

    uniform(1, 434, 3, 40);   // spread 40: rejected, divider stays 0
    uniform(1, 434, 0, 0);    // 115200 at 50 MHz -> 26
    uniform(1, 20, 0, 0);     // tiny bit -> 0
    uniform(1, 434, 0, 0);

    for (int n = 0; n < 8; n++) begin
      int base;
      base = $urandom_range(300, 20);
      foreach (w[i]) w[i] = base + $urandom_range(16, 0);
      if ($urandom_range(2, 0) == 0) w[$urandom_range(7, 0)] += $urandom_range(60, 17);
      run_frame(1, w);
    end

    // Abort after three pulses: no event, divider untouched.
    for (int i = 0; i < 3; i++) begin
      rxd1 = (i % 2) == 1;
      hold(200);
    end
    rxd1 = 1'b1;
    hold(6);
    chk("abort_busy_before", int'(busy1), 1);
    cfg1 = 1'b0;
    hold(1);
    chk("abort_busy", int'(busy1), 0);
    hold(20);
    chk("abort_baud", int'(baud1), good1);
    chk("abort_q_empty", q1.size(), 0);
    cfg1 = 1'b1;
    hold(2);

    // rxd held low after the start edge: 12-bit counter times out.
    begin
      exp_t e;
      e.err = 1'b1; e.baud = good2;
      q2.push_back(e);
    end
    rxd2 = 1'b0;
    hold(4200);
    wait_q(2);
    rxd2 = 1'b1;
    hold(10);
    chk("timeout_idle", int'(busy2), 0);

    uniform(2, 400, 0, 0);    // 24 saturates to 15
    uniform(2, 100, 0, 0);    // 6 - 1 = 5

    // Reset in the middle of a measurement.
    for (int i = 0; i < 3; i++) begin
      rxd1 = (i % 2) == 1;
      hold(150);
    end
    reset_n = 1'b0;
    rxd1 = 1'b1;
    hold(3);
    chk("midrst_baud1", int'(baud1), 0);
    chk("midrst_busy1", int'(busy1), 0);
    chk("midrst_enb1", enb_of(1), 0);
    chk("midrst_baud2", int'(baud2), 0);
    good1 = 0; good2 = 0;
    reset_n = 1'b1;
    hold(5);
    uniform(1, 250, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
